wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM→WB pipeline register plus writeback logic for the RV32I core.
- Captures the retiring instruction's destination, write enable, writeback-select and source data.
- Aligns and sign/zero-extends load data, then drives the register file write port (rd_addr / rd_wren / rd_data).
- Also provides a WB forwarding tap for upstream hazard logic and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- INSTRET_W, 32, width of retired-instruction counter.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_stall  in  1  hold WB register contents; suppress retire.
- i_flush  in  1  load a bubble into WB register.
- i_valid  in  1  MEM stage holds a real instruction.
- i_rd_addr  in  5  destination register.
- i_rd_wren  in  1  instruction writes rd.
- i_wb_sel  in  2  writeback source: 0 ALU, 1 load, 2 PC+4, 3 immediate (LUI).
- i_alu_data  in  32  ALU result; byte offset for loads is i_alu_data[1:0].
- i_pc_four  in  32  PC+4 for JAL/JALR.
- i_imm  in  32  U-immediate.
- i_ld_word  in  32  raw aligned word from LSU.
- i_ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- o_rd_addr  out  5  to regfile write address.
- o_rd_wren  out  1  to regfile write enable.
- o_rd_data  out  32  to regfile write data.
- o_fwd_valid  out  1  WB holds a valid instruction writing a nonzero rd.
- o_fwd_addr  out  5  forwarding tag (equals o_rd_addr).
- o_fwd_data  out  32  forwarding data (equals o_rd_data).
- o_ld_misalign  out  1  WB instruction is a misaligned load.
- o_instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (i_rst=1 at edge):
  - WB register cleared: valid=0, rd=0, wren=0, wb_sel=0, all data fields 0.
  - o_instret=0.
  - Consequently all outputs are 0 after reset.
- Register update priority at each edge: i_rst > i_flush > i_stall > load.
  - Flush: valid=0 and wren=0; other fields don't-care. Flush overrides stall.
  - Stall: all fields hold.
  - Otherwise capture all i_* fields.
- Latency: one cycle from MEM inputs to regfile write signals. Outputs are combinational from WB register only; there is no input-to-output combinational path.
- Retire cycle: retire = wb.valid & ~i_stall.
  - A stalled instruction retires exactly once, on the first cycle stall is low.
- o_rd_wren = retire & wb.wren & (wb.rd != 0) & ~o_ld_misalign.
  - x0 is never written from this block.
- o_fwd_valid = wb.valid & wb.wren & (wb.rd != 0) & ~o_ld_misalign. Asserts during stall (data is stable).
- Load extraction: off = wb.alu[1:0].
  - LB/LBU: byte at off, sign/zero-extended.
  - LH/LHU: halfword at off[1]; misaligned if off[0]=1.
  - LW: word; misaligned if off≠0.
  - Undefined funct3 (011, 110, 111): data=0, misalign=0.
- o_ld_misalign = wb.valid & (wb.wb_sel==1) & misaligned condition.
- o_rd_data mux per wb_sel: ALU, extracted load, PC+4, imm. Driven even when o_rd_wren=0.
- o_instret increments by 1 on each retire cycle, misaligned loads included. Wraps modulo 2^INSTRET_W.
- Simultaneous flush+stall: bubble inserted, no retire of the prior occupant.
- Reset mid-stall: discards the occupant, no write.

Decomposition:
- Shared package core_pkg:
  - wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4, WB_IMM).
  - ld_funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_reg_t struct for the WB register fields.
- One sub-module: load_align (combinational; inputs word, funct3, off; outputs data, misalign). Reused by later LSU work.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles with i_valid=1 → all outputs 0, o_instret=0. First capture occurs on the edge after i_rst falls.
- ALU writeback: rd=5, wb_sel=0, alu=0xDEADBEEF, valid=1 → next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF, o_instret=1.
- Load extension:
  - i_ld_word=0x80FF7F01, alu[1:0]=2 → LB gives 0xFFFFFFFF; LBU gives 0x000000FF.
  - LH at off=2 gives 0xFFFF80FF; LHU gives 0x000080FF.
  - LW at off=1 gives o_ld_misalign=1, o_rd_wren=0, o_instret still increments.
- Stall hold: capture rd=3, pc_four=0x104, wb_sel=2, then i_stall=1 for 3 cycles → o_rd_wren=0 and o_fwd_valid=1 with data 0x104 throughout. On the cycle stall drops, exactly one write and o_instret += 1.
- Flush over stall: i_flush=1, i_stall=1 together while WB holds valid rd=7 → next cycle o_fwd_valid=0, no write to rd=7, o_instret unchanged.
- x0 and wrap: rd=0 with wren=1 → o_rd_wren=0 but instret increments. Preload o_instret to 0xFFFFFFFF via a long run → next retire wraps it to 0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core types for the writeback path.
package core_pkg;

   localparam int XLEN_C = 32;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_IMM  = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic              valid;
      logic [4:0]        rd;
      logic              wren;
      wb_sel_e           wb_sel;
      logic [XLEN_C-1:0] alu;
      logic [XLEN_C-1:0] pc_four;
      logic [XLEN_C-1:0] imm;
      logic [XLEN_C-1:0] ld_word;
      logic [2:0]        ld_funct3;
   } wb_reg_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed byte/halfword from an aligned load word and extends it.
module load_align
   import core_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   output logic [31:0] data_o,
   output logic        misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (off_i)
         2'd0:    byte_v = word_i[7:0];
         2'd1:    byte_v = word_i[15:8];
         2'd2:    byte_v = word_i[23:16];
         default: byte_v = word_i[31:24];
      endcase
      half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
   end

   // Unknown funct3 yields zero data and no misalign so it can never trap.
   always_comb begin
      data_o     = '0;
      misalign_o = 1'b0;
      case (funct3_i)
         F3_LB:  data_o = {{24{byte_v[7]}}, byte_v};
         F3_LBU: data_o = {24'd0, byte_v};
         F3_LH: begin
            data_o     = {{16{half_v[15]}}, half_v};
            misalign_o = off_i[0];
         end
         F3_LHU: begin
            data_o     = {16'd0, half_v};
            misalign_o = off_i[0];
         end
         F3_LW: begin
            data_o     = word_i;
            misalign_o = (off_i != 2'd0);
         end
         default: begin
            data_o     = '0;
            misalign_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM->WB pipeline register, writeback mux, forwarding tap and instret counter.
module wb_stage
   import core_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int INSTRET_W = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [4:0]           i_rd_addr,
   input  logic                 i_rd_wren,
   input  logic [1:0]           i_wb_sel,
   input  logic [XLEN-1:0]      i_alu_data,
   input  logic [XLEN-1:0]      i_pc_four,
   input  logic [XLEN-1:0]      i_imm,
   input  logic [XLEN-1:0]      i_ld_word,
   input  logic [2:0]           i_ld_funct3,
   output logic [4:0]           o_rd_addr,
   output logic                 o_rd_wren,
   output logic [XLEN-1:0]      o_rd_data,
   output logic                 o_fwd_valid,
   output logic [4:0]           o_fwd_addr,
   output logic [XLEN-1:0]      o_fwd_data,
   output logic                 o_ld_misalign,
   output logic [INSTRET_W-1:0] o_instret
);

   wb_reg_t                wb_q, wb_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   logic                   retire;
   logic                   writes_rd;
   logic                   ld_mis_raw;
   logic                   ld_misalign;
   logic [XLEN-1:0]        ld_data;
   logic [XLEN-1:0]        rd_data;

   always_comb begin
      wb_d = wb_q;
      if (i_flush) begin
         wb_d.valid = 1'b0;
         wb_d.wren  = 1'b0;
      end else if (!i_stall) begin
         wb_d.valid     = i_valid;
         wb_d.rd        = i_rd_addr;
         wb_d.wren      = i_rd_wren;
         wb_d.wb_sel    = wb_sel_e'(i_wb_sel);
         wb_d.alu       = i_alu_data;
         wb_d.pc_four   = i_pc_four;
         wb_d.imm       = i_imm;
         wb_d.ld_word   = i_ld_word;
         wb_d.ld_funct3 = i_ld_funct3;
      end
   end

   // A stalled occupant counts only when the stall releases, so it retires once.
   assign retire    = wb_q.valid & ~i_stall;
   assign instret_d = instret_q + INSTRET_W'(retire);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wb_q      <= '0;
         instret_q <= '0;
      end else begin
         wb_q      <= wb_d;
         instret_q <= instret_d;
      end
   end

   load_align u_load_align (
      .word_i     (wb_q.ld_word),
      .funct3_i   (wb_q.ld_funct3),
      .off_i      (wb_q.alu[1:0]),
      .data_o     (ld_data),
      .misalign_o (ld_mis_raw)
   );

   assign ld_misalign = wb_q.valid & (wb_q.wb_sel == WB_LOAD) & ld_mis_raw;

   always_comb begin
      case (wb_q.wb_sel)
         WB_ALU:  rd_data = wb_q.alu;
         WB_LOAD: rd_data = ld_data;
         WB_PC4:  rd_data = wb_q.pc_four;
         default: rd_data = wb_q.imm;
      endcase
   end

   // x0 is hardwired zero and a faulting load must not update the regfile.
   assign writes_rd = wb_q.valid & wb_q.wren & (wb_q.rd != 5'd0) & ~ld_misalign;

   assign o_rd_addr     = wb_q.rd;
   assign o_rd_wren     = writes_rd & retire;
   assign o_rd_data     = rd_data;
   assign o_fwd_valid   = writes_rd;
   assign o_fwd_addr    = wb_q.rd;
   assign o_fwd_data    = rd_data;
   assign o_ld_misalign = ld_misalign;
   assign o_instret     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - bench for wb_stage: vector table, corner sequences and random traffic vs a model.
module tb_wb_stage;

   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          i_rst, i_stall, i_flush, i_valid, i_rd_wren;
   logic [4:0]    i_rd_addr;
   logic [1:0]    i_wb_sel;
   logic [31:0]   i_alu_data, i_pc_four, i_imm, i_ld_word;
   logic [2:0]    i_ld_funct3;
   logic [4:0]    o_rd_addr, o_fwd_addr;
   logic          o_rd_wren, o_fwd_valid, o_ld_misalign;
   logic [31:0]   o_rd_data, o_fwd_data;
   logic [IW-1:0] o_instret;

   always #5 clk = ~clk;

   wb_stage #(.XLEN(32), .INSTRET_W(IW)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
      .i_valid(i_valid), .i_rd_addr(i_rd_addr), .i_rd_wren(i_rd_wren),
      .i_wb_sel(i_wb_sel), .i_alu_data(i_alu_data), .i_pc_four(i_pc_four),
      .i_imm(i_imm), .i_ld_word(i_ld_word), .i_ld_funct3(i_ld_funct3),
      .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren), .o_rd_data(o_rd_data),
      .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr), .o_fwd_data(o_fwd_data),
      .o_ld_misalign(o_ld_misalign), .o_instret(o_instret)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: the instruction sitting in WB plus a retire count.
   bit          m_valid, m_wren, m_known;
   bit [4:0]    m_rd;
   bit [1:0]    m_sel;
   bit [31:0]   m_alu, m_pc4, m_imm, m_word;
   bit [2:0]    m_f3;
   int unsigned m_instret;

   task automatic model_load(output bit [31:0] d, output bit mis);
      int unsigned off, b, h;
      off = m_alu % 4;
      b   = (m_word >> (8 * off)) % 256;
      h   = (m_word >> (16 * (off / 2))) % 65536;
      d   = 0;
      mis = 0;
      case (m_f3)
         3'd0: d = (b >= 128) ? b - 256 : b;
         3'd4: d = b;
         3'd1: begin d = (h >= 32768) ? h - 65536 : h; mis = (off % 2) != 0; end
         3'd5: begin d = h; mis = (off % 2) != 0; end
         3'd2: begin d = m_word; mis = (off != 0); end
         default: begin d = 0; mis = 0; end
      endcase
   endtask

   task automatic model_edge();
      if (i_rst) begin
         m_valid = 0; m_wren = 0; m_rd = 0; m_sel = 0;
         m_alu = 0; m_pc4 = 0; m_imm = 0; m_word = 0; m_f3 = 0;
         m_instret = 0; m_known = 1;
      end else begin
         if (m_valid && !i_stall) m_instret = (m_instret + 1) % (1 << IW);
         if (i_flush) begin
            m_valid = 0; m_wren = 0; m_known = 0;
         end else if (!i_stall) begin
            m_valid = i_valid; m_rd = i_rd_addr; m_wren = i_rd_wren; m_sel = i_wb_sel;
            m_alu = i_alu_data; m_pc4 = i_pc_four; m_imm = i_imm;
            m_word = i_ld_word; m_f3 = i_ld_funct3; m_known = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle_check(input string tag);
      bit [31:0] ld, d;
      bit mis, fv;
      #1;
      model_load(ld, mis);
      mis = mis && m_valid && (m_sel == 2'd1);
      case (m_sel)
         2'd0: d = m_alu;
         2'd1: d = ld;
         2'd2: d = m_pc4;
         default: d = m_imm;
      endcase
      fv = m_valid && m_wren && (m_rd != 0) && !mis;
      chk({tag, ".rd_wren"}, 32'(o_rd_wren), 32'(fv && !i_stall));
      chk({tag, ".fwd_valid"}, 32'(o_fwd_valid), 32'(fv));
      chk({tag, ".misalign"}, 32'(o_ld_misalign), 32'(mis));
      chk({tag, ".instret"}, 32'(o_instret), m_instret);
      if (m_known) begin
         chk({tag, ".rd_addr"}, 32'(o_rd_addr), 32'(m_rd));
         chk({tag, ".fwd_addr"}, 32'(o_fwd_addr), 32'(m_rd));
         chk({tag, ".rd_data"}, o_rd_data, d);
         chk({tag, ".fwd_data"}, o_fwd_data, d);
      end
   endtask

   task automatic drive(input bit v, input bit [4:0] rd, input bit wr, input bit [1:0] sel,
                        input bit [31:0] alu, input bit [2:0] f3);
      i_valid = v; i_rd_addr = rd; i_rd_wren = wr; i_wb_sel = sel;
      i_alu_data = alu; i_ld_funct3 = f3;
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [2:0]  f3;
      logic [31:0] exp_data;
      logic        exp_mis;
      logic        exp_wren;
   } vec_t;

   vec_t vecs[15];
   int unsigned base;

   initial begin
      vecs[0]  = '{5'd5,  2'd0, 32'hDEADBEEF, 3'd0, 32'hDEADBEEF, 1'b0, 1'b1};
      vecs[1]  = '{5'd1,  2'd1, 32'd2,        3'd0, 32'hFFFFFFFF, 1'b0, 1'b1};
      vecs[2]  = '{5'd2,  2'd1, 32'd2,        3'd4, 32'h000000FF, 1'b0, 1'b1};
      vecs[3]  = '{5'd3,  2'd1, 32'd2,        3'd1, 32'hFFFF80FF, 1'b0, 1'b1};
      vecs[4]  = '{5'd4,  2'd1, 32'd2,        3'd5, 32'h000080FF, 1'b0, 1'b1};
      vecs[5]  = '{5'd6,  2'd1, 32'd1,        3'd2, 32'h80FF7F01, 1'b1, 1'b0};
      vecs[6]  = '{5'd7,  2'd1, 32'd0,        3'd2, 32'h80FF7F01, 1'b0, 1'b1};
      vecs[7]  = '{5'd8,  2'd1, 32'd1,        3'd0, 32'h0000007F, 1'b0, 1'b1};
      vecs[8]  = '{5'd9,  2'd1, 32'd3,        3'd4, 32'h00000080, 1'b0, 1'b1};
      vecs[9]  = '{5'd10, 2'd1, 32'd3,        3'd1, 32'hFFFF80FF, 1'b1, 1'b0};
      vecs[10] = '{5'd11, 2'd1, 32'd0,        3'd3, 32'h00000000, 1'b0, 1'b1};
      vecs[11] = '{5'd12, 2'd2, 32'd0,        3'd0, 32'h00000104, 1'b0, 1'b1};
      vecs[12] = '{5'd13, 2'd3, 32'd0,        3'd0, 32'h12345000, 1'b0, 1'b1};
      vecs[13] = '{5'd0,  2'd0, 32'h55,       3'd0, 32'h00000055, 1'b0, 1'b0};
      vecs[14] = '{5'd14, 2'd0, 32'd3,        3'd2, 32'h00000003, 1'b0, 1'b1};

      i_rst = 1; i_stall = 0; i_flush = 0;
      i_pc_four = 32'h104; i_imm = 32'h12345000; i_ld_word = 32'h80FF7F01;
      drive(1, 5'd5, 1, 2'd0, 32'hDEADBEEF, 3'd0);
      m_known = 0; m_valid = 0; m_instret = 0;

      // Reset with a live instruction on the inputs.
      step(); step();
      settle_check("reset");
      chk("reset.instret0", 32'(o_instret), 32'd0);
      chk("reset.wren0", 32'(o_rd_wren), 32'd0);
      chk("reset.data0", o_rd_data, 32'd0);
      i_rst = 0;
      settle_check("post_reset");
      chk("post_reset.fwd0", 32'(o_fwd_valid), 32'd0);
      step();
      i_valid = 0;
      settle_check("first_capture");
      chk("first_capture.wren", 32'(o_rd_wren), 32'd1);

      foreach (vecs[k]) begin
         drive(1, vecs[k].rd, 1, vecs[k].sel, vecs[k].alu, vecs[k].f3);
         base = m_instret;
         step();
         i_valid = 0;
         settle_check($sformatf("vec%0d", k));
         chk($sformatf("vec%0d.data", k), o_rd_data, vecs[k].exp_data);
         chk($sformatf("vec%0d.mis", k), 32'(o_ld_misalign), 32'(vecs[k].exp_mis));
         chk($sformatf("vec%0d.wren", k), 32'(o_rd_wren), 32'(vecs[k].exp_wren));
         chk($sformatf("vec%0d.instret", k), 32'(o_instret), (base + 1) % (1 << IW));
      end

      // Stall hold: occupant stays visible on the forward tap, writes once on release.
      drive(1, 5'd3, 1, 2'd2, 32'd0, 3'd0);
      step();
      i_valid = 0; i_stall = 1;
      base = m_instret;
      for (int c = 0; c < 3; c++) begin
         settle_check($sformatf("stall%0d", c));
         chk($sformatf("stall%0d.wren", c), 32'(o_rd_wren), 32'd0);
         chk($sformatf("stall%0d.fwd", c), 32'(o_fwd_valid), 32'd1);
         chk($sformatf("stall%0d.fdata", c), o_fwd_data, 32'h104);
         step();
      end
      i_stall = 0;
      settle_check("stall_rel");
      chk("stall_rel.wren", 32'(o_rd_wren), 32'd1);
      chk("stall_rel.addr", 32'(o_rd_addr), 32'd3);
      step();
      settle_check("stall_after");
      chk("stall_after.instret", 32'(o_instret), (base + 1) % (1 << IW));
      chk("stall_after.wren", 32'(o_rd_wren), 32'd0);

      // Flush together with stall: bubble in, prior occupant dropped.
      drive(1, 5'd7, 1, 2'd0, 32'h77, 3'd0);
      step();
      i_valid = 0; i_stall = 1; i_flush = 1;
      settle_check("fs_hold");
      base = m_instret;
      step();
      i_stall = 0; i_flush = 0;
      settle_check("fs_after");
      chk("fs_after.fwd", 32'(o_fwd_valid), 32'd0);
      chk("fs_after.wren", 32'(o_rd_wren), 32'd0);
      chk("fs_after.instret", 32'(o_instret), base);

      // Reset while stalled discards the occupant.
      drive(1, 5'd9, 1, 2'd0, 32'h99, 3'd0);
      step();
      i_valid = 0; i_stall = 1; i_rst = 1;
      step();
      i_stall = 0; i_rst = 0;
      settle_check("rst_stall");
      chk("rst_stall.wren", 32'(o_rd_wren), 32'd0);
      chk("rst_stall.instret", 32'(o_instret), 32'd0);

      // Counter wrap, x0 writes still retire.
      for (int c = 0; c < 400 && m_instret != (1 << IW) - 1; c++) begin
         drive(1, 5'd0, 1, 2'd0, $urandom, 3'd0);
         step();
         settle_check("wrap_run");
      end
      chk("wrap.max", 32'(o_instret), 32'(2 ** IW - 1));
      i_valid = 0;
      step();
      settle_check("wrap");
      chk("wrap.zero", 32'(o_instret), 32'd0);

      // Random traffic against the model.
      for (int c = 0; c < 800; c++) begin
         i_rst       = ($urandom_range(63) == 0);
         i_flush     = ($urandom_range(7) == 0);
         i_stall     = ($urandom_range(3) == 0);
         i_valid     = ($urandom_range(3) != 0);
         i_rd_addr   = 5'($urandom_range(31));
         i_rd_wren   = ($urandom_range(4) != 0);
         i_wb_sel    = 2'($urandom_range(3));
         i_alu_data  = $urandom;
         i_pc_four   = $urandom;
         i_imm       = $urandom;
         i_ld_word   = $urandom;
         i_ld_funct3 = 3'($urandom_range(7));
         settle_check("rand");
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
